mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port unified instruction/data memory between two requesters: port 0 (the multicycle core's memory interface) and port 1 (program loader / DMA engine). Sequences each access through a fixed wait-state window and returns a one-cycle acknowledge with read data. Sits between the core/loader and the memory, replacing the direct memory connection.

Parameters:
WAIT_CYCLES, 1, memory wait states; the BUSY phase lasts WAIT_CYCLES+1 cycles (legal range 0..15)
FIXED_PRI, 0, 0 = round-robin arbitration; 1 = port 0 always wins
AW, 32, address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
p0_req  input  1  port 0 request; held with fields stable until p0_ack
p0_we  input  1  port 0 write enable
p0_adr  input  AW  port 0 byte address
p0_wd  input  32  port 0 write data
p0_ack  output  1  one-cycle completion pulse
p0_rd  output  32  port 0 read data, valid while p0_ack=1
p1_req, p1_we, p1_adr, p1_wd, p1_ack, p1_rd  same directions and widths as port 0, for port 1
mem_we  output  1  memory write strobe
mem_adr  output  AW  memory address
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data (combinational from mem_adr)
busy  output  1  high in every non-IDLE state
owner  output  1  port currently granted; valid while busy=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; last-grant pointer=1, so port 0 wins the first tie. Reset asserted mid-access aborts it: no ack is issued, and a pending write strobe is dropped.
- States: IDLE, BUSY, RESP.
- IDLE: if no req, stay. If exactly one req, grant that port. If both req: FIXED_PRI=1 grants port 0; FIXED_PRI=0 grants the port that is not the last-grant pointer. On grant, register owner, we, adr and wd; load the wait counter with WAIT_CYCLES; go to BUSY. Update the last-grant pointer on grant.
- BUSY: mem_adr and mem_wd are driven from the latched registers; mem_adr=0 and mem_wd=0 outside BUSY. The counter decrements each cycle.
  - Counter=0 marks the final BUSY cycle. In that cycle mem_we=latched we; a write commits at that clock edge. Also at that edge, mem_rd is captured into the owner's rd register; the capture happens on writes too.
  - The final BUSY cycle transitions to RESP.
- RESP: exactly one cycle. ack of the owner port=1; rd holds the captured word. Next state is IDLE. The requester must drop req, or present a new request, at the edge leaving RESP.
- Latency: a req sampled in IDLE at edge t gives ack high in cycle t+WAIT_CYCLES+2. Throughput is one transaction per WAIT_CYCLES+3 cycles.
- A p*_rd register holds its value until that port's next completion.
- mem_we is never high outside the final BUSY cycle.
- Req changes during BUSY/RESP are ignored.
- A req dropped before ack is a protocol violation; the access still completes and ack is still pulsed.
- The non-granted port's ack is never high.

Test Plan:
- Reset defaults: drive reset=0 mid-BUSY of a write (p0_we=1, WAIT_CYCLES=1) -> all outputs 0 immediately; no mem_we pulse; after release the state is IDLE, busy=0.
- Single read: WAIT_CYCLES=1, p0_req=1, p0_adr=0x10, memory word 0xE3A00005 -> mem_adr=0x10 for 2 cycles; p0_ack pulses 3 cycles after the request is sampled; p0_rd=0xE3A00005; p1_ack stays 0.
- Single write: p1_req=1, p1_we=1, p1_adr=0x40, p1_wd=0xDEADBEEF -> mem_we high for exactly 1 cycle with mem_adr=0x40 and mem_wd=0xDEADBEEF; a later p0 read of 0x40 returns 0xDEADBEEF.
- Round-robin contention: FIXED_PRI=0, both ports hold req continuously for 4 transactions -> grant order 0,1,0,1; owner matches each ack; no two acks are high in the same cycle.
- Fixed priority: FIXED_PRI=1, both ports hold req for 3 transactions -> port 0 is granted all 3; port 1 is granted only after p0_req drops.
- Zero wait states: WAIT_CYCLES=0, back-to-back p0 reads of 0x0 and 0x4 -> BUSY lasts 1 cycle; acks are 3 cycles apart; the p0_rd values match memory contents.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle for the two requester ports and the memory side of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/memory view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_adr;
  logic [31:0]   p0_wd;
  logic          p0_ack;
  logic [31:0]   p0_rd;
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_adr;
  logic [31:0]   p1_wd;
  logic          p1_ack;
  logic [31:0]   p1_rd;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
  logic          busy;
  logic          owner;

  modport slave (
    input  p0_req, p0_we, p0_adr, p0_wd,
    output p0_ack, p0_rd,
    input  p1_req, p1_we, p1_adr, p1_wd,
    output p1_ack, p1_rd,
    output mem_we, mem_adr, mem_wd,
    input  mem_rd,
    output busy, owner
  );

  modport master (
    output p0_req, p0_we, p0_adr, p0_wd,
    input  p0_ack, p0_rd,
    output p1_req, p1_we, p1_adr, p1_wd,
    input  p1_ack, p1_rd,
    input  mem_we, mem_adr, mem_wd,
    output mem_rd,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port memory.
// Each access runs through a fixed wait-state window and ends with a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          FIXED_PRI   = 1'b0,
  parameter int unsigned AW          = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t        state_r;
  state_t        state_n;
  logic [3:0]    cnt_r;
  logic          last_r;
  logic          owner_r;
  logic          we_r;
  logic          busy_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_adr_r;
  logic [31:0]   mem_wd_r;
  logic          p0_ack_r;
  logic          p1_ack_r;
  logic [31:0]   p0_rd_r;
  logic [31:0]   p1_rd_r;

  logic          grant_s;
  logic          gport_s;
  logic          final_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_adr_s;
  logic [31:0]   sel_wd_s;
  logic          mem_we_n_s;

  // Next-state, grant selection and the look-ahead for the write strobe.
  always_comb begin
    state_n    = state_r;
    grant_s    = 1'b0;
    gport_s    = 1'b0;
    final_s    = (state_r == BUSY) && (cnt_r == 4'd0);
    case (state_r)
      IDLE: begin
        if (bus.p0_req && bus.p1_req) begin
          grant_s = 1'b1;
          gport_s = FIXED_PRI ? 1'b0 : ~last_r;
          state_n = BUSY;
        end else if (bus.p0_req) begin
          grant_s = 1'b1;
          gport_s = 1'b0;
          state_n = BUSY;
        end else if (bus.p1_req) begin
          grant_s = 1'b1;
          gport_s = 1'b1;
          state_n = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (final_s) begin
          state_n = RESP;
        end else begin
          state_n = BUSY;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    sel_we_s  = gport_s ? bus.p1_we  : bus.p0_we;
    sel_adr_s = gport_s ? bus.p1_adr : bus.p0_adr;
    sel_wd_s  = gport_s ? bus.p1_wd  : bus.p0_wd;

    // The strobe is registered, so it is raised one edge before the final BUSY cycle.
    if (grant_s) begin
      mem_we_n_s = (WAIT_LD == 4'd0) && sel_we_s;
    end else begin
      mem_we_n_s = (state_r == BUSY) && (cnt_r == 4'd1) && we_r;
    end
  end

  // State, latched request fields, memory-side outputs and per-port responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      we_r      <= 1'b0;
      busy_r    <= 1'b0;
      mem_we_r  <= 1'b0;
      mem_adr_r <= '0;
      mem_wd_r  <= 32'd0;
      p0_ack_r  <= 1'b0;
      p1_ack_r  <= 1'b0;
      p0_rd_r   <= 32'd0;
      p1_rd_r   <= 32'd0;
    end else begin
      state_r  <= state_n;
      busy_r   <= (state_n != IDLE);
      mem_we_r <= mem_we_n_s;
      p0_ack_r <= final_s && !owner_r;
      p1_ack_r <= final_s && owner_r;
      if (grant_s) begin
        owner_r   <= gport_s;
        last_r    <= gport_s;
        we_r      <= sel_we_s;
        cnt_r     <= WAIT_LD;
        mem_adr_r <= sel_adr_s;
        mem_wd_r  <= sel_wd_s;
      end else if (final_s) begin
        mem_adr_r <= '0;
        mem_wd_r  <= 32'd0;
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // Read data is captured on writes too, matching the memory's read-before-write port.
      if (final_s) begin
        if (owner_r) begin
          p1_rd_r <= bus.mem_rd;
        end else begin
          p0_rd_r <= bus.mem_rd;
        end
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.owner   = owner_r;
  assign bus.mem_we  = mem_we_r;
  assign bus.mem_adr = mem_adr_r;
  assign bus.mem_wd  = mem_wd_r;
  assign bus.p0_ack  = p0_ack_r;
  assign bus.p1_ack  = p1_ack_r;
  assign bus.p0_rd   = p0_rd_r;
  assign bus.p1_rd   = p1_rd_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances cover round-robin, fixed priority and zero wait states.
// A shared memory model serves all instances. Only one instance is active at any time.
module tb_mem_arbiter;

  typedef struct {
    int          dut;
    logic        port;
    logic [31:0] rd;
    int          cyc;
  } ack_t;

  typedef struct {
    int          dut;
    logic [31:0] adr;
    logic [31:0] wd;
  } wr_t;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  mem_init = 1'b1;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_err = 0;
  ack_t  ack_q[$];
  wr_t   wr_q[$];
  logic [31:0] mem [0:63];

  mem_arbiter_if #(.AW(32)) bus_a ();
  mem_arbiter_if #(.AW(32)) bus_b ();
  mem_arbiter_if #(.AW(32)) bus_c ();

  mem_arbiter #(.WAIT_CYCLES(1), .FIXED_PRI(1'b0), .AW(32)) u_rr (.clk(clk), .reset(reset), .bus(bus_a));
  mem_arbiter #(.WAIT_CYCLES(1), .FIXED_PRI(1'b1), .AW(32)) u_fp (.clk(clk), .reset(reset), .bus(bus_b));
  mem_arbiter #(.WAIT_CYCLES(0), .FIXED_PRI(1'b0), .AW(32)) u_zw (.clk(clk), .reset(reset), .bus(bus_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus_a.mem_rd = mem[bus_a.mem_adr[7:2]];
  assign bus_b.mem_rd = mem[bus_b.mem_adr[7:2]];
  assign bus_c.mem_rd = mem[bus_c.mem_adr[7:2]];

  // Memory model: word i holds 0xA0000000 | byte address, with two marked words.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i * 4);
      mem[4] <= 32'hE3A0_0005;
      mem[8] <= 32'hA5A5_A5A5;
    end else begin
      if (bus_a.mem_we) mem[bus_a.mem_adr[7:2]] <= bus_a.mem_wd;
      if (bus_b.mem_we) mem[bus_b.mem_adr[7:2]] <= bus_b.mem_wd;
      if (bus_c.mem_we) mem[bus_c.mem_adr[7:2]] <= bus_c.mem_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int dut, input logic a0, input logic a1, input logic own, input logic bsy,
                     input logic we, input logic [31:0] rd0, input logic [31:0] rd1,
                     input logic [31:0] adr, input logic [31:0] wd);
    ack_t e;
    wr_t  w;
    if (a0 || a1) begin
      chk("single_ack", {31'd0, a0 & a1}, 32'd0);
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", {31'd0, a1}, 32'hFFFF_FFFF);
      end else begin
        e = ack_q.pop_front();
        chk("ack_dut", 32'(dut), 32'(e.dut));
        chk("ack_port", {31'd0, a1}, {31'd0, e.port});
        chk("ack_rd", a1 ? rd1 : rd0, e.rd);
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("owner", {31'd0, own}, {31'd0, e.port});
        chk("busy_resp", {31'd0, bsy}, 32'd1);
      end
    end
    if (we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_we", adr, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        chk("we_dut", 32'(dut), 32'(w.dut));
        chk("we_adr", adr, w.adr);
        chk("we_wd", wd, w.wd);
      end
    end
  endtask

  // Monitor: responses and write strobes are compared away from the active edge.
  always @(negedge clk) begin
    mon(0, bus_a.p0_ack, bus_a.p1_ack, bus_a.owner, bus_a.busy, bus_a.mem_we,
        bus_a.p0_rd, bus_a.p1_rd, bus_a.mem_adr, bus_a.mem_wd);
    mon(1, bus_b.p0_ack, bus_b.p1_ack, bus_b.owner, bus_b.busy, bus_b.mem_we,
        bus_b.p0_rd, bus_b.p1_rd, bus_b.mem_adr, bus_b.mem_wd);
    mon(2, bus_c.p0_ack, bus_c.p1_ack, bus_c.owner, bus_c.busy, bus_c.mem_we,
        bus_c.p0_rd, bus_c.p1_rd, bus_c.mem_adr, bus_c.mem_wd);
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ack(input int dut, input logic port, input logic [31:0] rd, input int c);
    ack_t e;
    e.dut = dut; e.port = port; e.rd = rd; e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic push_wr(input int dut, input logic [31:0] adr, input logic [31:0] wd);
    wr_t w;
    w.dut = dut; w.adr = adr; w.wd = wd;
    wr_q.push_back(w);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (ack_q.size() != 0 || wr_q.size() != 0); i++) go(1);
    chk("drain", 32'(ack_q.size() + wr_q.size()), 32'd0);
    ack_q.delete();
    wr_q.delete();
    go(2);
  endtask

  task automatic chk_zero(input string tag, input logic bsy, input logic own, input logic we,
                          input logic a0, input logic a1, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1);
    chk({tag, "_busy"}, {31'd0, bsy}, 32'd0);
    chk({tag, "_owner"}, {31'd0, own}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_acks"}, {30'd0, a1, a0}, 32'd0);
    chk({tag, "_mem_adr"}, adr, 32'd0);
    chk({tag, "_mem_wd"}, wd, 32'd0);
    chk({tag, "_rd"}, rd0 | rd1, 32'd0);
  endtask

  task automatic idle_all();
    bus_a.p0_req = 1'b0; bus_a.p0_we = 1'b0; bus_a.p0_adr = 32'd0; bus_a.p0_wd = 32'd0;
    bus_a.p1_req = 1'b0; bus_a.p1_we = 1'b0; bus_a.p1_adr = 32'd0; bus_a.p1_wd = 32'd0;
    bus_b.p0_req = 1'b0; bus_b.p0_we = 1'b0; bus_b.p0_adr = 32'd0; bus_b.p0_wd = 32'd0;
    bus_b.p1_req = 1'b0; bus_b.p1_we = 1'b0; bus_b.p1_adr = 32'd0; bus_b.p1_wd = 32'd0;
    bus_c.p0_req = 1'b0; bus_c.p0_we = 1'b0; bus_c.p0_adr = 32'd0; bus_c.p0_wd = 32'd0;
    bus_c.p1_req = 1'b0; bus_c.p1_we = 1'b0; bus_c.p1_adr = 32'd0; bus_c.p1_wd = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n_adr;
    int n_p1;
    idle_all();
    #1;
    chk_zero("rst_a", bus_a.busy, bus_a.owner, bus_a.mem_we, bus_a.p0_ack, bus_a.p1_ack,
             bus_a.mem_adr, bus_a.mem_wd, bus_a.p0_rd, bus_a.p1_rd);
    chk_zero("rst_b", bus_b.busy, bus_b.owner, bus_b.mem_we, bus_b.p0_ack, bus_b.p1_ack,
             bus_b.mem_adr, bus_b.mem_wd, bus_b.p0_rd, bus_b.p1_rd);
    go(3);
    mem_init = 1'b0;
    reset = 1'b1;
    go(2);

    // Single read on port 0, one wait state.
    k = cyc;
    n_adr = 0;
    n_p1 = 0;
    bus_a.p0_adr = 32'h10;
    bus_a.p0_req = 1'b1;
    push_ack(0, 1'b0, 32'hE3A0_0005, k + 3);
    for (int i = 1; i <= 5; i++) begin
      go(1);
      if (bus_a.mem_adr == 32'h10) n_adr++;
      if (bus_a.p1_ack) n_p1++;
      if (cyc == k + 3) bus_a.p0_req = 1'b0;
    end
    chk("read_adr_cycles", 32'(n_adr), 32'd2);
    chk("read_no_p1_ack", 32'(n_p1), 32'd0);
    drain();
    chk("read_rd_hold", bus_a.p0_rd, 32'hE3A0_0005);

    // Single write on port 1, then read it back through port 0.
    k = cyc;
    bus_a.p1_adr = 32'h40; bus_a.p1_wd = 32'hDEAD_BEEF; bus_a.p1_we = 1'b1; bus_a.p1_req = 1'b1;
    push_wr(0, 32'h40, 32'hDEAD_BEEF);
    push_ack(0, 1'b1, 32'hA000_0040, k + 3);
    go(3);
    bus_a.p1_req = 1'b0; bus_a.p1_we = 1'b0;
    drain();
    k = cyc;
    bus_a.p0_adr = 32'h40; bus_a.p0_req = 1'b1;
    push_ack(0, 1'b0, 32'hDEAD_BEEF, k + 3);
    go(3);
    bus_a.p0_req = 1'b0;
    drain();

    // Reset in the first BUSY cycle of a write: no strobe, no ack, outputs cleared.
    bus_a.p0_adr = 32'h20; bus_a.p0_wd = 32'h1111_1111; bus_a.p0_we = 1'b1; bus_a.p0_req = 1'b1;
    go(1);
    #1;
    reset = 1'b0;
    #1;
    chk_zero("midrst", bus_a.busy, bus_a.owner, bus_a.mem_we, bus_a.p0_ack, bus_a.p1_ack,
             bus_a.mem_adr, bus_a.mem_wd, bus_a.p0_rd, bus_a.p1_rd);
    bus_a.p0_req = 1'b0; bus_a.p0_we = 1'b0;
    go(2);
    reset = 1'b1;
    go(3);
    chk("post_rst_busy", {31'd0, bus_a.busy}, 32'd0);
    k = cyc;
    bus_a.p1_adr = 32'h20; bus_a.p1_req = 1'b1;
    push_ack(0, 1'b1, 32'hA5A5_A5A5, k + 3);
    go(3);
    bus_a.p1_req = 1'b0;
    drain();

    // Round-robin: both ports hold req; last grant was port 1, so order is 0,1,0,1.
    k = cyc;
    bus_a.p0_adr = 32'h8; bus_a.p1_adr = 32'hC;
    bus_a.p0_req = 1'b1; bus_a.p1_req = 1'b1;
    push_ack(0, 1'b0, 32'hA000_0008, k + 3);
    push_ack(0, 1'b1, 32'hA000_000C, k + 7);
    push_ack(0, 1'b0, 32'hA000_0008, k + 11);
    push_ack(0, 1'b1, 32'hA000_000C, k + 15);
    go(15);
    bus_a.p0_req = 1'b0; bus_a.p1_req = 1'b0;
    drain();

    // Fixed priority: port 0 wins three times; port 1 only after port 0 drops.
    k = cyc;
    bus_b.p0_adr = 32'h10; bus_b.p1_adr = 32'h14;
    bus_b.p0_req = 1'b1; bus_b.p1_req = 1'b1;
    push_ack(1, 1'b0, 32'hE3A0_0005, k + 3);
    push_ack(1, 1'b0, 32'hE3A0_0005, k + 7);
    push_ack(1, 1'b0, 32'hE3A0_0005, k + 11);
    push_ack(1, 1'b1, 32'hA000_0014, k + 15);
    go(11);
    bus_b.p0_req = 1'b0;
    go(4);
    bus_b.p1_req = 1'b0;
    drain();

    // Zero wait states: back-to-back port 0 reads, acks three cycles apart.
    k = cyc;
    bus_c.p0_adr = 32'h0; bus_c.p0_req = 1'b1;
    push_ack(2, 1'b0, 32'hA000_0000, k + 2);
    push_ack(2, 1'b0, 32'hA000_0004, k + 5);
    go(2);
    bus_c.p0_adr = 32'h4;
    go(3);
    bus_c.p0_req = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
